dmem_resp: RTL and testbench
============================

# dmem_resp

Data-memory responder for the ARM core's load/store path. It accepts word requests from the datapath (address from the ALU result, store data from the register file) through a req/ready handshake, inserts a configurable number of wait states, and returns registered read data. It turns the single-cycle core's memory port into a multi-cycle bus slave, so cores and testbenches can be exercised against realistic memory latency.

## Interface
- DEPTH, 64: number of 32-bit words; power of two, ≥ 4.
- WAIT, 2: wait-state cycles per transaction; 0–15.

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  transaction request (level); held with addr/we/wdata stable until ready.
- we  in  1  1 = store word, 0 = load word.
- addr  in  32  byte address.
- wdata  in  32  store data.
- rdata  out  32  load data; registered.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error flag, valid only while ready = 1.
- busy  out  1  high while a transaction is in progress (WAIT or DONE).

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If req = 1, latch addr, we and wdata.
  - Load wait counter with WAIT.
  - Go to WAIT, or go directly to DONE when WAIT = 0.
  - If req = 0, stay in IDLE.
- WAIT: decrement the counter each cycle. When the counter reaches 1, the next state is DONE.
- Edge entering DONE:
  - Stores write mem[index] ← wdata.
  - Loads capture rdata ← mem[index].
  - Stores leave rdata unchanged.
- DONE: ready = 1 for exactly one cycle; unconditional return to IDLE.
- Requests are accepted only in IDLE. Changes to req, addr, we or wdata during WAIT or DONE are ignored.
- Each ready pulse completes exactly one transaction.
- The requester must drop req, or present a new request, in the cycle after ready. A req still high in IDLE starts a new transaction.
- Index: addr[log2(DEPTH)+1:2].
- The memory array is not reset. Contents are undefined until written.
- rdata holds its last value between transactions.

## Timing
- Reset values:
  - state = IDLE
  - ready = 0
  - err = 0
  - busy = 0
  - rdata = 32'h0
  - wait counter = 0
- Latency: req sampled high in IDLE cycle c gives ready = 1 in cycle c+WAIT+1. WAIT = 0 gives ready in cycle c+1.
- Back-to-back throughput: one transaction per WAIT+2 cycles.
- busy rises the cycle after acceptance and falls the cycle after DONE.
- Reset asserted mid-transaction:
  - The transaction is aborted immediately.
  - No ready pulse is produced.
  - A store is committed only if the DONE-entry edge has already occurred.
- Store followed by a load to the same word: the load returns the new data. No forwarding hazard exists, because transactions are serialised.

## Configuration
- DMEM_ERR_CHECK_EN defined:
  - Conditions flagged: addr[1:0] ≠ 0 (misaligned) or addr[31:2] ≥ DEPTH (out of range).
  - On a flagged transaction: err = 1 together with ready.
  - Stores are suppressed. The memory is unchanged.
  - Loads return rdata = 32'h0.
  - Handshake timing is unchanged.
- DMEM_ERR_CHECK_EN not defined:
  - err is tied to 0.
  - addr[1:0] is ignored.
  - Upper address bits are ignored, so the index wraps modulo DEPTH.

## Test plan
- Reset then idle, WAIT = 2: rdata = 0, ready = 0, busy = 0 for 10 cycles with req = 0.
- Store 32'hDEADBEEF to addr 0x10, then load 0x10:
  - Each ready arrives exactly 3 cycles after its req acceptance.
  - The load returns rdata = 32'hDEADBEEF with err = 0.
- WAIT = 0, alternating store/load to addr 0x04 with values 1, 2, 3: each ready follows acceptance by 1 cycle, and each load returns the preceding store value.
- With DMEM_ERR_CHECK_EN, store to 0x13 then load 0x10 (holding 32'h5):
  - The store completes with ready = 1 and err = 1.
  - The load returns 32'h5.
  - A load from 4*DEPTH returns err = 1, rdata = 0.
- Without DMEM_ERR_CHECK_EN, store 32'hA5 to 4*DEPTH + 8: a load from 0x08 returns 32'hA5, with err = 0 throughout.
- Reset asserted during WAIT of a store of 32'h77 to 0x20:
  - No ready pulse.
  - After the earlier value 32'h11 has been rewritten to 0x20 and the reset sequence completes, a load from 0x20 returns 32'h11, proving the aborted store was not committed.

Source files
------------

// File: rtl/dmem_resp.sv
// Word-wide data memory slave: req/ready handshake with WAIT wait states, registered load data.
// Optional DMEM_ERR_CHECK_EN flags misaligned/out-of-range accesses (err with ready, store dropped, load returns 0).
module dmem_resp #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [3:0]    cnt;
    logic          we_q;
    logic          bad_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          enter_done;
    logic          bad_in;
    logic [AW-1:0] idx_in;
    logic          we_sel;
    logic          bad_sel;
    logic [AW-1:0] idx_sel;
    logic [31:0]   wdata_sel;

    assign accept = (state == S_IDLE) && req;
    assign idx_in = addr[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign bad_in = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
`else
    logic unused_addr;
    assign bad_in      = 1'b0;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
`endif

    // With WAIT = 0 the DONE-entry edge is the acceptance edge, so use the live inputs.
    assign we_sel    = (state == S_IDLE) ? we     : we_q;
    assign bad_sel   = (state == S_IDLE) ? bad_in : bad_q;
    assign idx_sel   = (state == S_IDLE) ? idx_in : idx_q;
    assign wdata_sel = (state == S_IDLE) ? wdata  : wdata_q;

    assign enter_done = (accept && (WAIT_CNT == 4'd0)) || ((state == S_WAIT) && (cnt == 4'd1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req) state_nx = (WAIT_CNT == 4'd0) ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt == 4'd1) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            rdata   <= 32'h0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt     <= WAIT_CNT;
                we_q    <= we;
                bad_q   <= bad_in;
                idx_q   <= idx_in;
                wdata_q <= wdata;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_done && !we_sel)
                rdata <= bad_sel ? 32'h0 : mem[idx_sel];
        end
    end

    // Storage is deliberately unreset; reset gates the write so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (enter_done && we_sel && !bad_sel && reset)
            mem[idx_sel] <= wdata_sel;
    end

    assign ready = (state == S_DONE);
    assign busy  = (state != S_IDLE);

`ifdef DMEM_ERR_CHECK_EN
    assign err = ready && bad_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench: instance 0 runs WAIT=2, instance 1 runs WAIT=0; a monitor checks every ready pulse.
module tb_dmem_resp;
    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          at;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_o [2];
    logic        ready_o [2];
    logic        err_o   [2];
    logic        busy_o  [2];

    int          cyc;
    int          total;
    int          bad;
    logic [31:0] last_rd [2];
    exp_t        q0[$];
    exp_t        q1[$];

    dmem_resp #(.DEPTH(DEPTH), .WAIT(2)) u_w2 (
        .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .rdata(rdata_o[0]), .ready(ready_o[0]), .err(err_o[0]), .busy(busy_o[0])
    );

    dmem_resp #(.DEPTH(DEPTH), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .rdata(rdata_o[1]), .ready(ready_o[1]), .err(err_o[1]), .busy(busy_o[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int i);
        exp_t e;
        int   depth;
        depth = (i == 0) ? q0.size() : q1.size();
        if (depth == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready inst%0d: got ready=1 want no pulse (cycle %0d)", i, cyc);
        end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rdata inst%0d", i), rdata_o[i], e.rd);
            chk($sformatf("err inst%0d", i), {31'b0, err_o[i]}, {31'b0, e.err});
            chk($sformatf("latency inst%0d", i), cyc, e.at);
        end
    endtask

    always @(negedge clk) begin
        if (ready_o[0] === 1'b1) mon(0);
        if (ready_o[1] === 1'b1) mon(1);
    end

    // Issue one transaction and hold it until ready; expected response goes to the scoreboard.
    task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        bit   seen;
        @(negedge clk);
        req_s[i]   = 1'b1;
        we_s[i]    = w;
        addr_s[i]  = a;
        wdata_s[i] = d;
        e.at  = cyc + 1 + ((i == 0) ? 2 : 0);
        e.err = exp_err;
        e.rd  = w ? last_rd[i] : exp_rd;
        if (!w) last_rd[i] = exp_rd;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) chk($sformatf("busy_after_accept inst%0d", i), {31'b0, busy_o[i]}, 32'd1);
            if (ready_o[i] === 1'b1) seen = 1'b1;
        end
        req_s[i] = 1'b0;
        if (!seen) chk($sformatf("ready_timeout inst%0d", i), 32'd0, 32'd1);
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b0;
        cyc   = 0;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 2; i++) begin
            req_s[i]   = 1'b0;
            we_s[i]    = 1'b0;
            addr_s[i]  = 32'h0;
            wdata_s[i] = 32'h0;
            last_rd[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Idle after reset
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("idle_rdata inst%0d", i), rdata_o[i], 32'h0);
                chk($sformatf("idle_ready inst%0d", i), {31'b0, ready_o[i]}, 32'd0);
                chk($sformatf("idle_busy inst%0d", i), {31'b0, busy_o[i]}, 32'd0);
            end
        end

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        for (int v = 1; v <= 3; v++) begin
            txn(1, 1'b1, 32'h04, 32'(v), 32'h0, 1'b0);
            txn(1, 1'b0, 32'h04, 32'h0, 32'(v), 1'b0);
        end

`ifdef DMEM_ERR_CHECK_EN
        txn(0, 1'b1, 32'h10, 32'h5, 32'h0, 1'b0);
        txn(0, 1'b1, 32'h13, 32'h99, 32'h0, 1'b1);
        txn(0, 1'b0, 32'h10, 32'h0, 32'h5, 1'b0);
        txn(0, 1'b0, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);
`else
        txn(0, 1'b1, 32'(4 * DEPTH + 8), 32'hA5, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h08, 32'h0, 32'hA5, 1'b0);
`endif

        // Abort a store mid-wait; the earlier value must survive
        txn(0, 1'b1, 32'h20, 32'h11, 32'h0, 1'b0);
        @(negedge clk);
        req_s[0]   = 1'b1;
        we_s[0]    = 1'b1;
        addr_s[0]  = 32'h20;
        wdata_s[0] = 32'h77;
        @(negedge clk);
        chk("busy_before_abort", {31'b0, busy_o[0]}, 32'd1);
        reset    = 1'b0;
        req_s[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("ready_in_reset", {31'b0, ready_o[0]}, 32'd0);
            chk("busy_in_reset", {31'b0, busy_o[0]}, 32'd0);
        end
        reset = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk);
        chk("rdata_after_reset inst0", rdata_o[0], 32'h0);
        chk("rdata_after_reset inst1", rdata_o[1], 32'h0);
        txn(0, 1'b0, 32'h20, 32'h0, 32'h11, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
